instruction_prefetch_unit: RTL and testbench



---
 rtl/instruction_prefetch_unit_pkg.sv | 24 ++
 rtl/instruction_prefetch_unit_fifo.sv | 49 ++++
 rtl/instruction_prefetch_unit.sv | 179 +++++++++++++++++
 tb/tb_instruction_prefetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } ifu_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI arsize encoding: log2 of bytes per beat.
  function automatic logic [2:0] axi_size_enc(input int unsigned nbytes);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == nbytes) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/instruction_prefetch_unit_fifo.sv
// Prefetch FIFO: registered storage, synchronous flush, occupancy count.
module sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  // Head is forced to zero when empty so outputs read clean after reset/flush.
  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush empties the queue and overrides push/pop.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the head is gated by empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Sequential instruction prefetcher: AXI4 INCR burst reader feeding a FIFO,
// with redirect flushing queued words and discarding in-flight beats.
module instruction_prefetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int AXI_ID     = 0,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_err,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [1:0]        m_axi_arburst,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = DATA_W + ADDR_W + 1;

  ifu_state_e        r_state;
  logic [ADDR_W-1:0] r_next_pc;
  logic [ADDR_W-1:0] r_beat_pc;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [4:0]        r_beats;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_halted;
  logic              r_redir_pend;

  logic [4:0]        w_word_idx;
  logic [4:0]        w_beats;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [CNT_W-1:0]  w_free;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_can_issue;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_beat_err;
  logic              w_push;
  logic              w_pop;
  logic [FW-1:0]     w_push_data;
  logic [FW-1:0]     w_pop_data;

  // Beats up to the next burst-aligned boundary; that boundary divides 4 KB,
  // so no burst can cross a 4 KB page.
  assign w_word_idx  = 5'((r_next_pc >> OFF_W) & ADDR_W'(BURST_LEN - 1));
  assign w_beats     = 5'(BURST_LEN) - w_word_idx;
  assign w_free      = CNT_W'(FIFO_DEPTH) - w_fifo_count;
  assign w_can_issue = fetch_enable && !r_halted && (32'(w_free) >= 32'(w_beats));

  assign w_ar_hs     = r_arvalid && m_axi_arready;
  assign w_r_hs      = r_rready && m_axi_rvalid;
  assign w_beat_err  = (m_axi_rresp != AXI_RESP_OKAY);
  assign w_push      = (r_state == DATA) && w_r_hs && !redirect_valid && (!w_fifo_full || w_pop);
  assign w_pop       = !w_fifo_empty && instr_ready && !redirect_valid;
  assign w_push_data = {w_beat_err, r_beat_pc, m_axi_rdata};

  assign instr_valid = !w_fifo_empty;
  assign instr_err   = w_pop_data[FW-1];
  assign instr_pc    = w_pop_data[DATA_W +: ADDR_W];
  assign instr_data  = w_pop_data[DATA_W-1:0];

  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arid    = ID_W'(AXI_ID);
  assign m_axi_arsize  = axi_size_enc(BYTES);

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_pop_data),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // Fetch FSM: issue one burst at a time, collect or discard its beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_next_pc    <= '0;
      r_beat_pc    <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_beats      <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_halted     <= 1'b0;
      r_redir_pend <= 1'b0;
    end else begin
      if (redirect_valid) begin
        r_next_pc <= redirect_addr;
        r_halted  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (!redirect_valid && w_can_issue) begin
            r_state      <= REQ;
            r_arvalid    <= 1'b1;
            r_araddr     <= r_next_pc;
            r_beat_pc    <= r_next_pc;
            r_arlen      <= 8'(w_beats - 5'd1);
            r_beats      <= w_beats;
            r_redir_pend <= 1'b0;
          end
        end
        REQ: begin
          // A redirect cannot retract arvalid; remember it and drain the burst.
          if (redirect_valid) r_redir_pend <= 1'b1;
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            if (redirect_valid || r_redir_pend) begin
              r_state <= DRAIN;
            end else begin
              r_state   <= DATA;
              r_next_pc <= r_next_pc + (ADDR_W'(r_beats) << OFF_W);
            end
          end
        end
        DATA: begin
          if (w_r_hs) begin
            r_beat_pc <= r_beat_pc + ADDR_W'(BYTES);
            if (w_beat_err && !redirect_valid) r_halted <= 1'b1;
            if (m_axi_rlast) begin
              r_rready <= 1'b0;
              r_state  <= IDLE;
            end else if (redirect_valid) begin
              r_state <= DRAIN;
            end
          end else if (redirect_valid) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_r_hs && m_axi_rlast) begin
            r_rready <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
module tb_instruction_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] m_axi_araddr;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arid;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  instruction_prefetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_err      (instr_err),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arburst  (m_axi_arburst),
    .m_axi_arid     (m_axi_arid),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_arsize   (m_axi_arsize),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rlast    (m_axi_rlast),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } pop_t;
  typedef struct {
    logic [31:0] redir;
    logic [31:0] ar0;
    logic [7:0]  len0;
    logic [31:0] ar1;
    logic [7:0]  len1;
  } vec_t;

  ar_t  ar_q[$];
  pop_t pop_q[$];
  int   rhs_cnt;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] s_err_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  // AXI read slave: one burst at a time, data is a function of address.
  initial begin : slave
    bit          n_ar, n_r, n_rst, act;
    logic [31:0] n_addr, base;
    int          n_len, len, beat;
    act = 0; base = 0; len = 0; beat = 0;
    m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
    forever begin
      @(negedge clk);
      n_rst  = reset;
      n_ar   = !reset && m_axi_arvalid && m_axi_arready;
      n_r    = !reset && m_axi_rvalid && m_axi_rready;
      n_addr = m_axi_araddr;
      n_len  = int'(m_axi_arlen);
      if (n_ar) ar_q.push_back('{addr: m_axi_araddr, len: m_axi_arlen});
      if (n_r) rhs_cnt++;
      if (!reset && instr_valid && instr_ready && !redirect_valid)
        pop_q.push_back('{pc: instr_pc, data: instr_data, err: instr_err});
      @(posedge clk);
      #1;
      if (n_rst) begin
        act = 0;
      end else begin
        if (n_r) begin
          if (beat == len) act = 0;
          else beat++;
        end
        if (n_ar) begin
          act = 1; base = n_addr; len = n_len; beat = 0;
        end
      end
      m_axi_rvalid = act;
      m_axi_rdata  = mem_word(base + 32'(beat * 4));
      m_axi_rlast  = act && (beat == len);
      m_axi_rresp  = ((base + 32'(beat * 4)) == s_err_addr) ? 2'b10 : 2'b00;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    total++;
    bad++;
    $display("FAIL %s: %s", name, why);
  endtask

  task automatic wait_ar(input int n, input string name);
    int c = 0;
    while (ar_q.size() < n && c < 200) begin step(1); c++; end
    if (ar_q.size() < n) fail_now(name, "timeout waiting for AR");
  endtask

  task automatic wait_pop(input int n, input string name);
    int c = 0;
    while (pop_q.size() < n && c < 200) begin step(1); c++; end
    if (pop_q.size() < n) fail_now(name, "timeout waiting for instruction");
  endtask

  task automatic wait_rhs(input int n, input string name);
    int c = 0;
    while (rhs_cnt < n && c < 200) begin step(1); c++; end
    if (rhs_cnt < n) fail_now(name, "timeout waiting for R beat");
  endtask

  task automatic chk_ar(input int i, input logic [31:0] a, input logic [7:0] l, input string name);
    if (i >= ar_q.size()) fail_now(name, "AR missing");
    else begin
      chk({name, "_addr"}, ar_q[i].addr, a);
      chk({name, "_len"}, 32'(ar_q[i].len), 32'(l));
    end
  endtask

  task automatic chk_pop(input int i, input logic [31:0] pc, input logic err, input string name);
    if (i >= pop_q.size()) fail_now(name, "instruction missing");
    else begin
      chk({name, "_pc"}, pop_q[i].pc, pc);
      chk({name, "_data"}, pop_q[i].data, mem_word(pc));
      chk({name, "_err"}, 32'(pop_q[i].err), 32'(err));
    end
  endtask

  task automatic do_reset();
    reset = 1; fetch_enable = 0; redirect_valid = 0; redirect_addr = 0;
    instr_ready = 0; m_axi_arready = 1; s_err_addr = 32'hFFFF_FFFF;
    step(3);
    ar_q.delete(); pop_q.delete(); rhs_cnt = 0;
    reset = 0;
    step(1);
  endtask

  task automatic redirect(input logic [31:0] a);
    redirect_valid = 1; redirect_addr = a;
    step(1);
    redirect_valid = 0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{redir: 32'h0000_0000, ar0: 32'h0000_0000, len0: 8'd3, ar1: 32'h0000_0010, len1: 8'd3};
    vecs[1] = '{redir: 32'h0000_0008, ar0: 32'h0000_0008, len0: 8'd1, ar1: 32'h0000_0010, len1: 8'd3};
    vecs[2] = '{redir: 32'h0000_0004, ar0: 32'h0000_0004, len0: 8'd2, ar1: 32'h0000_0010, len1: 8'd3};
    vecs[3] = '{redir: 32'h0000_000C, ar0: 32'h0000_000C, len0: 8'd0, ar1: 32'h0000_0010, len1: 8'd3};
    vecs[4] = '{redir: 32'h0000_1FF4, ar0: 32'h0000_1FF4, len0: 8'd2, ar1: 32'h0000_2000, len1: 8'd3};
    vecs[5] = '{redir: 32'h0000_0FFC, ar0: 32'h0000_0FFC, len0: 8'd0, ar1: 32'h0000_1000, len1: 8'd3};

    // Reset values
    do_reset();
    chk("rst_arvalid", 32'(m_axi_arvalid), 0);
    chk("rst_rready", 32'(m_axi_rready), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_instr_data", instr_data, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_instr_err", 32'(instr_err), 0);
    chk("rst_arburst", 32'(m_axi_arburst), 1);
    chk("rst_arid", 32'(m_axi_arid), 0);
    chk("rst_arsize", 32'(m_axi_arsize), 2);
    step(5);
    chk("rst_no_ar_without_enable", 32'(ar_q.size()), 0);

    // Burst splitting and in-order delivery from several redirect targets
    for (int v = 0; v < 6; v++) begin
      do_reset();
      instr_ready = 1; fetch_enable = 1;
      redirect(vecs[v].redir);
      chk($sformatf("v%0d_idle_after_redirect", v), 32'(m_axi_arvalid), 0);
      step(1);
      chk($sformatf("v%0d_arvalid_t1", v), 32'(m_axi_arvalid), 1);
      wait_ar(2, $sformatf("v%0d_wait_ar", v));
      chk_ar(0, vecs[v].ar0, vecs[v].len0, $sformatf("v%0d_ar0", v));
      chk_ar(1, vecs[v].ar1, vecs[v].len1, $sformatf("v%0d_ar1", v));
      wait_pop(4, $sformatf("v%0d_wait_pop", v));
      for (int i = 0; i < 4; i++)
        chk_pop(i, vecs[v].redir + 32'(4 * i), 1'b0, $sformatf("v%0d_pop%0d", v, i));
    end

    // Stalled consumer: reservation limits outstanding data to the FIFO size
    do_reset();
    fetch_enable = 1;
    redirect(32'h0);
    step(40);
    chk("stall_two_bursts", 32'(ar_q.size()), 2);
    chk("stall_arvalid_low", 32'(m_axi_arvalid), 0);
    chk("stall_head_valid", 32'(instr_valid), 1);
    instr_ready = 1; step(3); instr_ready = 0;
    step(20);
    chk("stall_three_pops_no_ar", 32'(ar_q.size()), 2);
    instr_ready = 1; step(1); instr_ready = 0;
    step(20);
    chk("stall_fourth_pop_ar", 32'(ar_q.size()), 3);
    chk_ar(2, 32'h20, 8'd3, "stall_ar2");
    for (int i = 0; i < 4; i++) chk_pop(i, 32'(4 * i), 1'b0, $sformatf("stall_pop%0d", i));

    // Redirect during a burst: its remaining beats are discarded
    do_reset();
    fetch_enable = 1;
    redirect(32'h40);
    wait_rhs(2, "mid_wait_beats");
    chk_ar(0, 32'h40, 8'd3, "mid_ar0");
    redirect(32'h100);
    instr_ready = 1;
    wait_pop(2, "mid_wait_pop");
    chk_pop(0, 32'h100, 1'b0, "mid_pop0");
    chk_pop(1, 32'h104, 1'b0, "mid_pop1");
    chk_ar(1, 32'h100, 8'd3, "mid_ar1");

    // Redirect while AR is stalled: arvalid holds, burst is drained
    do_reset();
    fetch_enable = 1; instr_ready = 1; m_axi_arready = 0;
    redirect(32'h0);
    step(1);
    chk("req_arvalid", 32'(m_axi_arvalid), 1);
    redirect(32'h300);
    chk("req_arvalid_held", 32'(m_axi_arvalid), 1);
    chk("req_araddr_held", m_axi_araddr, 32'h0);
    chk("req_arlen_held", 32'(m_axi_arlen), 3);
    step(2);
    m_axi_arready = 1;
    wait_ar(2, "req_wait_ar");
    chk_ar(1, 32'h300, 8'd3, "req_ar1");
    wait_pop(1, "req_wait_pop");
    chk_pop(0, 32'h300, 1'b0, "req_pop0");

    // Error response halts fetch until redirect
    do_reset();
    fetch_enable = 1; instr_ready = 1; s_err_addr = 32'h4;
    redirect(32'h0);
    step(40);
    chk("err_single_ar", 32'(ar_q.size()), 1);
    for (int i = 0; i < 4; i++)
      chk_pop(i, 32'(4 * i), (i == 1), $sformatf("err_pop%0d", i));
    s_err_addr = 32'hFFFF_FFFF;
    redirect(32'h200);
    wait_ar(2, "err_wait_ar");
    chk_ar(1, 32'h200, 8'd3, "err_resume_ar");
    wait_pop(5, "err_wait_pop");
    chk_pop(4, 32'h200, 1'b0, "err_resume_pop");

    // Reset in the middle of a burst
    do_reset();
    fetch_enable = 1;
    redirect(32'h0);
    wait_rhs(2, "rst_wait_beats");
    reset = 1; fetch_enable = 0;
    step(1);
    chk("midrst_arvalid", 32'(m_axi_arvalid), 0);
    chk("midrst_rready", 32'(m_axi_rready), 0);
    chk("midrst_instr_valid", 32'(instr_valid), 0);
    ar_q.delete(); pop_q.delete();
    reset = 0;
    step(20);
    chk("midrst_no_ar", 32'(ar_q.size()), 0);
    fetch_enable = 1; instr_ready = 1;
    wait_ar(1, "midrst_wait_ar");
    chk_ar(0, 32'h0, 8'd3, "midrst_ar0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
